nano_prog_loader: RTL and testbench

NANO_PROG_LOADER -- requirements
Module: nano_prog_loader

---
 rtl/nano_prog_loader.sv | 271 +++++++++++++++++++++++++++
 tb/tb_nano_prog_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nano_prog_loader.sv
// UART program loader: receives a framed program image over 8N1 serial and writes it
// into program memory word by word. Define LOADER_CHECKSUM_EN to add a trailing XOR checksum byte.
module nano_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        load_en,
  input  logic        rx,
  output logic [15:0] pm_addr,
  output logic [31:0] pm_data,
  output logic        pm_wr,
  output logic        cpu_nreset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYNC   = 3'd1;
  localparam logic [2:0] ST_CNT_LO = 3'd2;
  localparam logic [2:0] ST_CNT_HI = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHK    = 3'd5;
`endif
  localparam logic [2:0] ST_DONE   = 3'd6;
  localparam logic [2:0] ST_ERROR  = 3'd7;

`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] FRAME_END = ST_CHK;
`else
  localparam logic [2:0] FRAME_END = ST_DONE;
`endif

  // ---------------------------------------------------------------- rx sync
  logic rx_meta, rx_sync, rx_prev;
  logic rx_fall;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // ---------------------------------------------------------------- uart receiver
  logic [1:0]       rx_state, rx_state_nxt;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]       rx_bit, rx_bit_nxt;
  logic [7:0]       rx_shift, rx_shift_nxt;
  logic             rx_vld, rx_vld_nxt;
  logic             rx_ferr, rx_ferr_nxt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_vld   <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
      rx_vld   <= rx_vld_nxt;
      rx_ferr  <= rx_ferr_nxt;
    end
  end

  // Start is confirmed at mid-bit; every later sample lands one bit period on.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_vld_nxt   = 1'b0;
    rx_ferr_nxt  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_nxt = RX_START;
          rx_cnt_nxt   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nxt = '0;
          rx_bit_nxt = '0;
          rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_nxt = rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_shift_nxt = {rx_sync, rx_shift[7:1]};
          rx_bit_nxt   = rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
        end else begin
          rx_cnt_nxt = rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = RX_IDLE;
          rx_vld_nxt   = rx_sync;
          rx_ferr_nxt  = ~rx_sync;
        end else begin
          rx_cnt_nxt = rx_cnt + 1'b1;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- loader fsm
  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] n_words, n_words_nxt;
  logic [ADDR_W-1:0] word_idx, word_idx_nxt;
  logic [1:0]        byte_idx, byte_idx_nxt;
  logic [23:0]       word_buf, word_buf_nxt;
  logic [ADDR_W-1:0] pm_addr_nxt;
  logic [DATA_W-1:0] pm_data_nxt;
  logic              pm_wr_nxt;
  logic              busy_nxt, done_nxt, error_nxt, cpu_nreset_nxt;
  logic [ADDR_W-1:0] n_words_hi;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk_xor, chk_xor_nxt;
`endif

  assign n_words_hi = {rx_shift, n_words[7:0]};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= ST_IDLE;
      n_words    <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      pm_addr    <= '0;
      pm_data    <= '0;
      pm_wr      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_nreset <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_xor    <= '0;
`endif
    end else begin
      state      <= state_nxt;
      n_words    <= n_words_nxt;
      word_idx   <= word_idx_nxt;
      byte_idx   <= byte_idx_nxt;
      word_buf   <= word_buf_nxt;
      pm_addr    <= pm_addr_nxt;
      pm_data    <= pm_data_nxt;
      pm_wr      <= pm_wr_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      error      <= error_nxt;
      cpu_nreset <= cpu_nreset_nxt;
`ifdef LOADER_CHECKSUM_EN
      chk_xor    <= chk_xor_nxt;
`endif
    end
  end

  // Dropping load_en outranks any byte or framing error arriving in the same cycle.
  always_comb begin
    state_nxt    = state;
    n_words_nxt  = n_words;
    word_idx_nxt = word_idx;
    byte_idx_nxt = byte_idx;
    word_buf_nxt = word_buf;
    pm_addr_nxt  = pm_addr;
    pm_data_nxt  = pm_data;
    pm_wr_nxt    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    chk_xor_nxt  = chk_xor;
`endif
    case (state)
      ST_IDLE: begin
        if (load_en) begin
          state_nxt    = ST_SYNC;
          n_words_nxt  = '0;
          word_idx_nxt = '0;
          byte_idx_nxt = '0;
          word_buf_nxt = '0;
`ifdef LOADER_CHECKSUM_EN
          chk_xor_nxt  = '0;
`endif
        end
      end
      ST_DONE, ST_ERROR: begin
        if (!load_en) state_nxt = ST_IDLE;
      end
      default: begin
        if (!load_en) begin
          state_nxt = ST_IDLE;
        end else if (rx_ferr) begin
          state_nxt = ST_ERROR;
        end else if (rx_vld) begin
          case (state)
            ST_SYNC: begin
              if (rx_shift == SYNC_BYTE) state_nxt = ST_CNT_LO;
            end
            ST_CNT_LO: begin
              n_words_nxt = {8'h00, rx_shift};
              state_nxt   = ST_CNT_HI;
            end
            ST_CNT_HI: begin
              n_words_nxt = n_words_hi;
              state_nxt   = (n_words_hi == '0) ? FRAME_END : ST_DATA;
            end
            ST_DATA: begin
              byte_idx_nxt = byte_idx + 1'b1;
              word_buf_nxt = {rx_shift, word_buf[23:8]};
`ifdef LOADER_CHECKSUM_EN
              chk_xor_nxt  = chk_xor ^ rx_shift;
`endif
              if (byte_idx == 2'd3) begin
                pm_wr_nxt    = 1'b1;
                pm_data_nxt  = {rx_shift, word_buf};
                pm_addr_nxt  = word_idx;
                word_idx_nxt = word_idx + 1'b1;
                if (word_idx == n_words - 1'b1) state_nxt = FRAME_END;
              end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
              state_nxt = (rx_shift == chk_xor) ? ST_DONE : ST_ERROR;
            end
`endif
            default: state_nxt = ST_IDLE;
          endcase
        end
      end
    endcase
    busy_nxt       = (state_nxt != ST_IDLE) && (state_nxt != ST_DONE) && (state_nxt != ST_ERROR);
    done_nxt       = (state_nxt == ST_DONE);
    error_nxt      = (state_nxt == ST_ERROR);
    cpu_nreset_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_DONE);
  end

endmodule

// File: tb/tb_nano_prog_loader.sv
// Directed bench for nano_prog_loader: serial frames driven on rx, writes captured and checked.
module tb_nano_prog_loader;

  localparam int unsigned CPB = 16;

  logic        clk = 1'b0;
  logic        nreset;
  logic        load_en;
  logic        rx;
  logic [15:0] pm_addr;
  logic [31:0] pm_data;
  logic        pm_wr;
  logic        cpu_nreset;
  logic        busy;
  logic        done;
  logic        error;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] wr_addr [$];
  logic [31:0] wr_data [$];

  nano_prog_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .load_en    (load_en),
    .rx         (rx),
    .pm_addr    (pm_addr),
    .pm_data    (pm_data),
    .pm_wr      (pm_wr),
    .cpu_nreset (cpu_nreset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Record every write strobe seen mid-cycle.
  always @(negedge clk) begin
    if (pm_wr) begin
      wr_addr.push_back(pm_addr);
      wr_data.push_back(pm_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_bits(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic tx(input logic [7:0] b);
    tx_bits(b, 1'b1);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [15:0] a, input logic [31:0] d);
    if (wr_addr.size() > idx) begin
      check({tag, "_addr"}, 32'(wr_addr[idx]), 32'(a));
      check({tag, "_data"}, wr_data[idx], d);
    end else begin
      check({tag, "_present"}, 32'(wr_addr.size()), 32'(idx + 1));
    end
  endtask

  task automatic check_flags(input string tag, input logic b, input logic d, input logic e, input logic c);
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_error"}, 32'(error), 32'(e));
    check({tag, "_cpu_nreset"}, 32'(cpu_nreset), 32'(c));
  endtask

  task automatic finish_load(input string tag);
    load_en = 1'b0;
    idle(2);
    check_flags(tag, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    nreset  = 1'b0;
    load_en = 1'b0;
    rx      = 1'b1;
    #1;
    check("rst_pm_addr", 32'(pm_addr), 32'h0);
    check("rst_pm_data", pm_data, 32'h0);
    check("rst_pm_wr", 32'(pm_wr), 32'h0);
    check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    nreset = 1'b1;
    idle(2);
    check("idle_cpu_nreset", 32'(cpu_nreset), 32'h1);

    // Two-word program.
    clear_log();
    load_en = 1'b1;
    idle(2);
    check_flags("sync", 1'b1, 1'b0, 1'b0, 1'b0);
    tx(8'hA5); tx(8'h02); tx(8'h00);
    tx(8'h13); tx(8'h00); tx(8'h00); tx(8'h00);
    tx(8'h93); tx(8'h00); tx(8'h10); tx(8'h00);
`ifdef LOADER_CHECKSUM_EN
    tx(8'h90);
`endif
    idle(4);
    check("two_wr_count", 32'(wr_addr.size()), 32'd2);
    check_wr("two_w0", 0, 16'd0, 32'h0000_0013);
    check_wr("two_w1", 1, 16'd1, 32'h0010_0093);
    check("two_hold_addr", 32'(pm_addr), 32'd1);
    check("two_hold_data", pm_data, 32'h0010_0093);
    check_flags("two_done", 1'b0, 1'b1, 1'b0, 1'b1);
    finish_load("two_exit");

    // Leading junk bytes are skipped until the sync marker.
    clear_log();
    load_en = 1'b1;
    tx(8'h00); tx(8'hFF);
    check_flags("junk", 1'b1, 1'b0, 1'b0, 1'b0);
    tx(8'hA5); tx(8'h01); tx(8'h00);
    tx(8'hEF); tx(8'hBE); tx(8'hAD); tx(8'hDE);
`ifdef LOADER_CHECKSUM_EN
    tx(8'h22);
`endif
    idle(4);
    check("junk_wr_count", 32'(wr_addr.size()), 32'd1);
    check_wr("junk_w0", 0, 16'd0, 32'hDEAD_BEEF);
    check("junk_done", 32'(done), 32'h1);
    finish_load("junk_exit");

    // Framing error on the low count byte.
    clear_log();
    load_en = 1'b1;
    tx(8'hA5);
    tx_bits(8'h02, 1'b0);
    idle(4);
    check_flags("ferr", 1'b0, 1'b0, 1'b1, 1'b0);
    check("ferr_wr_count", 32'(wr_addr.size()), 32'd0);
    finish_load("ferr_exit");

    // Zero-length program.
    clear_log();
    load_en = 1'b1;
    tx(8'hA5); tx(8'h00); tx(8'h00);
`ifdef LOADER_CHECKSUM_EN
    tx(8'h00);
`endif
    idle(4);
    check_flags("zero", 1'b0, 1'b1, 1'b0, 1'b1);
    check("zero_wr_count", 32'(wr_addr.size()), 32'd0);
    finish_load("zero_exit");

`ifdef LOADER_CHECKSUM_EN
    // Bad then good checksum.
    clear_log();
    load_en = 1'b1;
    tx(8'hA5); tx(8'h01); tx(8'h00);
    tx(8'h01); tx(8'h02); tx(8'h03); tx(8'h04); tx(8'h05);
    idle(4);
    check_flags("badchk", 1'b0, 1'b0, 1'b1, 1'b0);
    finish_load("badchk_exit");
    load_en = 1'b1;
    tx(8'hA5); tx(8'h01); tx(8'h00);
    tx(8'h01); tx(8'h02); tx(8'h03); tx(8'h04); tx(8'h04);
    idle(4);
    check_flags("goodchk", 1'b0, 1'b1, 1'b0, 1'b1);
    finish_load("goodchk_exit");
`endif

    // Abort mid-word: no write, clean return to idle.
    clear_log();
    load_en = 1'b1;
    tx(8'hA5); tx(8'h01); tx(8'h00);
    tx(8'h11); tx(8'h22); tx(8'h33);
    finish_load("abort");
    tx(8'h44);
    idle(4);
    check("abort_wr_count", 32'(wr_addr.size()), 32'd0);

    // Reset mid-download, then leftovers ignored and a fresh frame loads at 0.
    clear_log();
    load_en = 1'b1;
    tx(8'hA5); tx(8'h02); tx(8'h00); tx(8'h11); tx(8'h22);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    check("midrst_pm_addr", 32'(pm_addr), 32'h0);
    check("midrst_pm_data", pm_data, 32'h0);
    check("midrst_pm_wr", 32'(pm_wr), 32'h0);
    check_flags("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    nreset = 1'b1;
    tx(8'h33); tx(8'h44);
    // A short low glitch must not start a byte.
    @(negedge clk);
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(3 * CPB);
    check_flags("glitch", 1'b1, 1'b0, 1'b0, 1'b0);
    check("glitch_wr_count", 32'(wr_addr.size()), 32'd0);
    tx(8'hA5); tx(8'h01); tx(8'h00);
    tx(8'h44); tx(8'h33); tx(8'h22); tx(8'h11);
`ifdef LOADER_CHECKSUM_EN
    tx(8'h44);
`endif
    idle(4);
    check("fresh_wr_count", 32'(wr_addr.size()), 32'd1);
    check_wr("fresh_w0", 0, 16'd0, 32'h1122_3344);
    check("fresh_done", 32'(done), 32'h1);
    finish_load("fresh_exit");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
